wb_result_stage: RTL and testbench

WB_RESULT_STAGE -- requirements
Module: wb_result_stage

---
 rtl/wb_result_stage.sv | 98 +++++++++
 tb/tb_wb_result_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_result_stage.sv
// Writeback stage: formats the load/ALU/link result and drives the register-file write port.
// Latency: 1 cycle (single pipeline register); retired_o counts instructions leaving the stage.
// Backpressure: stall_i holds all state, flush_i kills the held instruction, reset overrides both.
module wb_result_stage #(
    parameter logic [31:0] RETIRED_INIT = 32'h0000_0000  // counter value loaded on reset
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] aluResult_i,
    input  logic [31:0] memData_i,
    input  logic [31:0] pcPlus4_i,
    input  logic [1:0]  ResultSrc_signal_i,
    input  logic [2:0]  loadType_i,
    input  logic [4:0]  rd_i,
    input  logic        RegWrite_signal_i,
    output logic [31:0] regWriteData_o,
    output logic [4:0]  regWriteAddr_o,
    output logic        regWriteEn_o,
    output logic [31:0] retired_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] result_d;

    logic        valid_q;
    logic        regwrite_q;
    logic [4:0]  rd_q;
    logic [31:0] data_q;
    logic [31:0] retired_q;

    always_comb begin
        ld_byte   = memData_i[7:0];
        ld_half   = memData_i[15:0];
        load_data = memData_i;
        result_d  = aluResult_i;

        case (aluResult_i[1:0])
            2'd1:    ld_byte = memData_i[15:8];
            2'd2:    ld_byte = memData_i[23:16];
            2'd3:    ld_byte = memData_i[31:24];
            default: ld_byte = memData_i[7:0];
        endcase

        // Halfword offset bit 0 is deliberately ignored (misaligned halves are not split).
        if (aluResult_i[1]) begin
            ld_half = memData_i[31:16];
        end

        case (loadType_i)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {24'h0, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_data = {16'h0, ld_half};
            default: load_data = memData_i;
        endcase

        case (ResultSrc_signal_i)
            2'b01:   result_d = load_data;
            2'b10:   result_d = pcPlus4_i;
            default: result_d = aluResult_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= 5'd0;
            data_q     <= 32'd0;
            retired_q  <= RETIRED_INIT;
        end else begin
            // An instruction retires only when it actually leaves: not stalled, not killed.
            if (valid_q && !stall_i && !flush_i) begin
                retired_q <= retired_q + 32'd1;
            end

            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (!stall_i) begin
                valid_q    <= valid_i;
                regwrite_q <= RegWrite_signal_i;
                rd_q       <= rd_i;
                data_q     <= result_d;
            end
        end
    end

    assign regWriteData_o = data_q;
    assign regWriteAddr_o = rd_q;
    assign regWriteEn_o   = valid_q && regwrite_q && (rd_q != 5'd0);
    assign retired_o      = retired_q;

endmodule

// File: tb/tb_wb_result_stage.sv
// Bench for wb_result_stage: directed vector table, stall/flush/reset/wrap sequences, random vs reference model.
module tb_wb_result_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] aluResult_i;
    logic [31:0] memData_i;
    logic [31:0] pcPlus4_i;
    logic [1:0]  ResultSrc_signal_i;
    logic [2:0]  loadType_i;
    logic [4:0]  rd_i;
    logic        RegWrite_signal_i;

    logic [31:0] regWriteData_o;
    logic [4:0]  regWriteAddr_o;
    logic        regWriteEn_o;
    logic [31:0] retired_o;

    logic [31:0] w_data;
    logic [4:0]  w_addr;
    logic        w_en;
    logic [31:0] w_retired;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    wb_result_stage dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .aluResult_i(aluResult_i), .memData_i(memData_i), .pcPlus4_i(pcPlus4_i),
        .ResultSrc_signal_i(ResultSrc_signal_i), .loadType_i(loadType_i), .rd_i(rd_i),
        .RegWrite_signal_i(RegWrite_signal_i),
        .regWriteData_o(regWriteData_o), .regWriteAddr_o(regWriteAddr_o),
        .regWriteEn_o(regWriteEn_o), .retired_o(retired_o)
    );

    // Second instance preloaded two below the wrap point to exercise counter rollover.
    wb_result_stage #(.RETIRED_INIT(32'hFFFF_FFFE)) dut_w (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .aluResult_i(aluResult_i), .memData_i(memData_i), .pcPlus4_i(pcPlus4_i),
        .ResultSrc_signal_i(ResultSrc_signal_i), .loadType_i(loadType_i), .rd_i(rd_i),
        .RegWrite_signal_i(RegWrite_signal_i),
        .regWriteData_o(w_data), .regWriteAddr_o(w_addr),
        .regWriteEn_o(w_en), .retired_o(w_retired)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic [1:0]  src;
        logic [2:0]  lt;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] exp_data;
        logic        exp_en;
    } vec_t;

    vec_t vecs[12];

    // Reference model state: what the stage should be holding.
    logic        m_v;
    logic        m_rw;
    logic [4:0]  m_rd;
    logic [31:0] m_d;
    logic [31:0] m_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc, input logic [1:0] src, input logic [2:0] lt,
                         input logic [4:0] rd, input logic rw);
        valid_i = v; aluResult_i = alu; memData_i = mem; pcPlus4_i = pc;
        ResultSrc_signal_i = src; loadType_i = lt; rd_i = rd; RegWrite_signal_i = rw;
    endtask

    function automatic logic [31:0] model_result(input logic [31:0] alu, input logic [31:0] mem,
                                                 input logic [31:0] pc, input logic [1:0] src,
                                                 input logic [2:0] lt);
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] ld;
        b = (mem >> (8 * (alu % 4))) % 256;
        h = (mem >> (16 * ((alu / 2) % 2))) % 65536;
        case (lt)
            3'd0:    ld = (b >= 128) ? b - 32'd256 : b;
            3'd4:    ld = b;
            3'd1:    ld = (h >= 32768) ? h - 32'd65536 : h;
            3'd5:    ld = h;
            default: ld = mem;
        endcase
        if (src == 2'd1)      return ld;
        else if (src == 2'd2) return pc;
        else                  return alu;
    endfunction

    task automatic model_edge();
        if (!rst_ni) begin
            m_v = 0; m_rw = 0; m_rd = 0; m_d = 0; m_ret = 0;
        end else begin
            if (m_v && !stall_i && !flush_i) m_ret = m_ret + 1;
            if (flush_i) begin
                m_v = 0;
            end else if (!stall_i) begin
                m_v = valid_i; m_rw = RegWrite_signal_i; m_rd = rd_i;
                m_d = model_result(aluResult_i, memData_i, pcPlus4_i, ResultSrc_signal_i, loadType_i);
            end
        end
    endtask

    initial begin
        vecs[0]  = '{32'h0000_1234, 32'h0,         32'h0,     2'b00, 3'b000, 5'd5,  1'b1, 32'h0000_1234, 1'b1};
        vecs[1]  = '{32'h0000_0002, 32'h80FF_7F01, 32'h0,     2'b01, 3'b000, 5'd6,  1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[2]  = '{32'h0000_0003, 32'h80FF_7F01, 32'h0,     2'b01, 3'b100, 5'd7,  1'b1, 32'h0000_0080, 1'b1};
        vecs[3]  = '{32'h0000_0002, 32'h80FF_7F01, 32'h0,     2'b01, 3'b001, 5'd8,  1'b1, 32'hFFFF_80FF, 1'b1};
        vecs[4]  = '{32'h0000_0000, 32'h80FF_7F01, 32'h0,     2'b01, 3'b101, 5'd9,  1'b1, 32'h0000_7F01, 1'b1};
        vecs[5]  = '{32'h0000_0001, 32'h80FF_7F01, 32'h0,     2'b01, 3'b010, 5'd10, 1'b1, 32'h80FF_7F01, 1'b1};
        vecs[6]  = '{32'h0000_DEAD, 32'h0,         32'h0,     2'b00, 3'b000, 5'd0,  1'b1, 32'h0000_DEAD, 1'b0};
        vecs[7]  = '{32'h0000_0000, 32'h0,         32'h104,   2'b10, 3'b000, 5'd1,  1'b1, 32'h0000_0104, 1'b1};
        vecs[8]  = '{32'hCAFE_F00D, 32'h1111_2222, 32'h200,   2'b11, 3'b000, 5'd31, 1'b1, 32'hCAFE_F00D, 1'b1};
        vecs[9]  = '{32'h0000_0055, 32'h0,         32'h0,     2'b00, 3'b000, 5'd3,  1'b0, 32'h0000_0055, 1'b0};
        vecs[10] = '{32'h0000_0003, 32'h80FF_7F01, 32'h0,     2'b01, 3'b001, 5'd11, 1'b1, 32'hFFFF_80FF, 1'b1};
        vecs[11] = '{32'h0000_0001, 32'h80FF_7F01, 32'h0,     2'b01, 3'b111, 5'd12, 1'b1, 32'h80FF_7F01, 1'b1};

        rst_ni = 0; stall_i = 0; flush_i = 0;
        drive(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 3'b000, 5'd31, 1);
        step();
        chk("reset_data", regWriteData_o, 32'h0);
        chk("reset_addr", {27'd0, regWriteAddr_o}, 32'h0);
        chk("reset_en", {31'd0, regWriteEn_o}, 32'h0);
        chk("reset_retired", retired_o, 32'h0);
        chk("reset_retired_w", w_retired, 32'hFFFF_FFFE);
        rst_ni = 1;

        // Back-to-back table: one instruction per cycle, each counted when the next replaces it.
        for (int i = 0; i < 12; i++) begin
            drive(1, vecs[i].alu, vecs[i].mem, vecs[i].pc, vecs[i].src, vecs[i].lt, vecs[i].rd, vecs[i].rw);
            step();
            chk($sformatf("vec%0d_data", i), regWriteData_o, vecs[i].exp_data);
            chk($sformatf("vec%0d_addr", i), {27'd0, regWriteAddr_o}, {27'd0, vecs[i].rd});
            chk($sformatf("vec%0d_en", i), {31'd0, regWriteEn_o}, {31'd0, vecs[i].exp_en});
            chk($sformatf("vec%0d_retired", i), retired_o, i);
        end

        // Stall holds A for three cycles, then flush-with-stall kills it uncounted.
        drive(1, 32'h0000_AAAA, 32'h0, 32'h0, 2'b00, 3'b000, 5'd7, 1);
        step();
        chk("stall_capture_data", regWriteData_o, 32'h0000_AAAA);
        chk("stall_capture_retired", retired_o, 32'd12);
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h0000_BBBB + i, 32'h0, 32'h0, 2'b00, 3'b000, 5'd9, 1);
            step();
            chk($sformatf("stall%0d_data", i), regWriteData_o, 32'h0000_AAAA);
            chk($sformatf("stall%0d_addr", i), {27'd0, regWriteAddr_o}, 32'd7);
            chk($sformatf("stall%0d_en", i), {31'd0, regWriteEn_o}, 32'd1);
            chk($sformatf("stall%0d_retired", i), retired_o, 32'd12);
        end
        flush_i = 1;
        step();
        chk("flush_en", {31'd0, regWriteEn_o}, 32'd0);
        chk("flush_retired", retired_o, 32'd12);
        flush_i = 0; stall_i = 0; valid_i = 0;
        step();
        chk("after_flush_retired", retired_o, 32'd12);
        chk("after_flush_en", {31'd0, regWriteEn_o}, 32'd0);

        // Reset in the middle of a stream, overriding a stall.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h100 + i, 32'h0, 32'h0, 2'b00, 3'b000, 5'd4, 1);
            step();
        end
        rst_ni = 0; stall_i = 1;
        step();
        chk("midrst_data", regWriteData_o, 32'h0);
        chk("midrst_addr", {27'd0, regWriteAddr_o}, 32'h0);
        chk("midrst_en", {31'd0, regWriteEn_o}, 32'h0);
        chk("midrst_retired", retired_o, 32'h0);
        rst_ni = 1; stall_i = 0;
        drive(1, 32'h0000_0B0B, 32'h0, 32'h0, 2'b00, 3'b000, 5'd2, 1);
        step();
        chk("post_rst_en", {31'd0, regWriteEn_o}, 32'd1);
        chk("post_rst_retired0", retired_o, 32'd0);
        chk("wrap_hold", w_retired, 32'hFFFF_FFFE);
        drive(1, 32'h0000_0C0C, 32'h0, 32'h0, 2'b00, 3'b000, 5'd3, 1);
        step();
        chk("post_rst_retired1", retired_o, 32'd1);
        chk("wrap_max", w_retired, 32'hFFFF_FFFF);
        valid_i = 0;
        step();
        chk("post_rst_retired2", retired_o, 32'd2);
        chk("wrap_zero", w_retired, 32'h0);

        // Randomized traffic against the reference model.
        rst_ni = 0;
        model_edge();
        step();
        rst_ni = 1;
        for (int i = 0; i < 400; i++) begin
            rst_ni  = ($urandom_range(0, 49) != 0);
            stall_i = ($urandom_range(0, 3) == 0);
            flush_i = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 4) != 0, $urandom, $urandom, $urandom,
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3) != 0);
            model_edge();
            step();
            chk($sformatf("rnd%0d_en", i), {31'd0, regWriteEn_o}, {31'd0, m_v && m_rw && (m_rd != 0)});
            chk($sformatf("rnd%0d_retired", i), retired_o, m_ret);
            chk($sformatf("rnd%0d_retired_w", i), w_retired, m_ret + 32'hFFFF_FFFE);
            if (m_v) begin
                chk($sformatf("rnd%0d_data", i), regWriteData_o, m_d);
                chk($sformatf("rnd%0d_addr", i), {27'd0, regWriteAddr_o}, {27'd0, m_rd});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
